// File: rtl/tlul_mem_arb_pkg.sv
// Shared types for the main-memory TL-UL arbiter: TL-UL A/D channel structs,
// arbiter FSM states and host index helpers.
package tlul_mem_arb_pkg;

  localparam int MaxOutstandingDefault = 8;
  localparam int NumHostsDefault       = 4;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  function automatic int host_idx_w(int num_hosts);
    return (num_hosts > 1) ? $clog2(num_hosts) : 1;
  endfunction

  typedef logic [host_idx_w(NumHostsDefault)-1:0] host_idx_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_mem_arbiter_if.sv
// Host-side and device-side TL-UL bundle of the main-memory arbiter.
// slave: arbiter view; master: system/bench view.
interface tlul_mem_arbiter_if #(
  parameter int NumHosts = 4
);
  import tlul_mem_arb_pkg::*;

  tl_h2d_t tl_h_i [NumHosts];
  tl_d2h_t tl_h_o [NumHosts];
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;
  logic    busy_o;
  logic    err_o;

  modport slave (
    input  tl_h_i, tl_d_i,
    output tl_h_o, tl_d_o, busy_o, err_o
  );

  modport master (
    output tl_h_i, tl_d_i,
    input  tl_h_o, tl_d_o, busy_o, err_o
  );
endinterface

// File: rtl/tlul_mem_arb_fifo.sv
// Synchronous FIFO holding granted host indices in request order.
// Head visible combinationally; caller must not push when full or pop when empty.
module tlul_mem_arb_fifo #(
  parameter int Depth = 8,
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/tlul_mem_arbiter.sv
// Round-robin arbiter sharing the DDR4 TL-UL bridge between NumHosts hosts, 0-cycle A and D paths.
// Optional MEM_ARB_PERF_CNT_EN adds saturating per-host grant and stall counters.
module tlul_mem_arbiter
  import tlul_mem_arb_pkg::*;
#(
  parameter int NumHosts       = 4,
  parameter int MaxOutstanding = MaxOutstandingDefault
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  tlul_mem_arbiter_if.slave         bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [NumHosts-1:0][31:0] perf_grant_o,
  output logic [31:0]               perf_stall_o
`endif
);

  localparam int HostIdxW = host_idx_w(NumHosts);

  arb_state_e          state_q, state_d;
  logic [HostIdxW-1:0] rr_ptr_q;
  logic [HostIdxW-1:0] lock_idx_q;
  logic                err_q;

  logic                win_vld;
  logic [HostIdxW-1:0] win_idx;
  logic                grant_vld;
  logic [HostIdxW-1:0] grant_idx;
  logic                dev_a_vld;
  logic                accept;

  logic                fifo_full;
  logic                fifo_empty;
  logic [HostIdxW-1:0] head_idx;
  logic                dev_d_rdy;
  logic                pop;

  tl_h2d_t             dev_req;
  tl_d2h_t             host_rsp [NumHosts];

  // Highest offset first so the host closest to rr_ptr is the final assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NumHosts - 1; i >= 0; i--) begin
      int j;
      j = int'(rr_ptr_q) + i;
      if (j >= NumHosts) j = j - NumHosts;
      if (bus.tl_h_i[j].a_valid) begin
        win_vld = 1'b1;
        win_idx = HostIdxW'(j);
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ARB;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (dev_a_vld && !bus.tl_d_i.a_ready) state_d = HOLD;
      HOLD:    if (accept) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Output logic: grant selection and device-side A valid
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = win_idx;
    case (state_q)
      ARB:     grant_vld = win_vld && !fifo_full;
      HOLD: begin
        grant_vld = 1'b1;
        grant_idx = lock_idx_q;
      end
      default: grant_vld = 1'b0;
    endcase
    dev_a_vld = grant_vld && bus.tl_h_i[grant_idx].a_valid;
    accept    = dev_a_vld && bus.tl_d_i.a_ready;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ARB && dev_a_vld && !bus.tl_d_i.a_ready) lock_idx_q <= win_idx;
      if (accept) begin
        rr_ptr_q <= (grant_idx == HostIdxW'(NumHosts - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (fifo_empty && bus.tl_d_i.d_valid) err_q <= 1'b1;
    end
  end

  tlul_mem_arb_fifo #(
    .Depth (MaxOutstanding),
    .Width (HostIdxW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .wdata_i (grant_idx),
    .pop_i   (pop),
    .rdata_o (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A spurious response is sunk so the device never wedges on it.
  assign dev_d_rdy = fifo_empty ? bus.tl_d_i.d_valid : bus.tl_h_i[head_idx].d_ready;
  assign pop       = !fifo_empty && bus.tl_d_i.d_valid && dev_d_rdy;

  always_comb begin
    dev_req         = bus.tl_h_i[grant_idx];
    dev_req.a_valid = dev_a_vld;
    dev_req.d_ready = dev_d_rdy;
    for (int i = 0; i < NumHosts; i++) begin
      host_rsp[i]         = bus.tl_d_i;
      host_rsp[i].a_ready = grant_vld && (grant_idx == HostIdxW'(i)) && bus.tl_d_i.a_ready;
      host_rsp[i].d_valid = !fifo_empty && (head_idx == HostIdxW'(i)) && bus.tl_d_i.d_valid;
    end
  end

  assign bus.tl_d_o = dev_req;
  assign bus.tl_h_o = host_rsp;
  assign bus.busy_o = !fifo_empty;
  assign bus.err_o  = err_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic any_a_vld;

  always_comb begin
    any_a_vld = 1'b0;
    for (int i = 0; i < NumHosts; i++) any_a_vld = any_a_vld | bus.tl_h_i[i].a_valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grant_o <= '0;
      perf_stall_o <= '0;
    end else begin
      for (int i = 0; i < NumHosts; i++) begin
        if (accept && grant_idx == HostIdxW'(i) && perf_grant_o[i] != 32'hFFFF_FFFF) begin
          perf_grant_o[i] <= perf_grant_o[i] + 32'd1;
        end
      end
      if (any_a_vld && !accept && perf_stall_o != 32'hFFFF_FFFF) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tlul_mem_arbiter.sv
// Directed table-driven bench for tlul_mem_arbiter (4 hosts, 8 outstanding).
module tb_tlul_mem_arbiter;
  import tlul_mem_arb_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  tlul_mem_arbiter_if #(.NumHosts(4)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
  logic [3:0][31:0] perf_grant;
  logic [31:0]      perf_stall;
`endif

  tlul_mem_arbiter #(
    .NumHosts       (4),
    .MaxOutstanding (8)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_grant_o (perf_grant),
    .perf_stall_o (perf_stall)
`endif
  );

  typedef struct {
    string       name;
    logic [3:0]  hv;
    logic        ar;
    logic        dv;
    logic [3:0]  hdr;
    logic [31:0] dd;
    logic        e_av;
    logic [7:0]  e_src;
    logic [3:0]  e_ar;
    logic [3:0]  e_dv;
    logic        e_dr;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int   perf_at;

  function automatic vec_t mk(string n, logic [3:0] hv, logic ar, logic dv, logic [3:0] hdr,
                              logic [31:0] dd, logic e_av, logic [7:0] e_src, logic [3:0] e_ar,
                              logic [3:0] e_dv, logic e_dr, logic e_busy, logic e_err);
    vec_t v;
    v.name = n;  v.hv = hv;  v.ar = ar;  v.dv = dv;  v.hdr = hdr;  v.dd = dd;
    v.e_av = e_av;  v.e_src = e_src;  v.e_ar = e_ar;  v.e_dv = e_dv;
    v.e_dr = e_dr;  v.e_busy = e_busy;  v.e_err = e_err;
    return v;
  endfunction

  function automatic void add(string n, logic [3:0] hv, logic ar, logic dv, logic [3:0] hdr,
                              logic [31:0] dd, logic e_av, logic [7:0] e_src, logic [3:0] e_ar,
                              logic [3:0] e_dv, logic e_dr, logic e_busy, logic e_err);
    vq.push_back(mk(n, hv, ar, dv, hdr, dd, e_av, e_src, e_ar, e_dv, e_dr, e_busy, e_err));
  endfunction

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", n, got, exp);
    end
  endtask

  task automatic drive(vec_t v);
    for (int i = 0; i < 4; i++) begin
      bus.tl_h_i[i].a_valid = v.hv[i];
      bus.tl_h_i[i].d_ready = v.hdr[i];
    end
    bus.tl_d_i.a_ready = v.ar;
    bus.tl_d_i.d_valid = v.dv;
    bus.tl_d_i.d_data  = v.dd;
  endtask

  // Drive on the falling edge, compare 1 ns later, the rising edge commits.
  task automatic apply(vec_t v);
    logic [3:0] got_ar;
    logic [3:0] got_dv;
    @(negedge clk_i);
    drive(v);
    #1;
    for (int i = 0; i < 4; i++) begin
      got_ar[i] = bus.tl_h_o[i].a_ready;
      got_dv[i] = bus.tl_h_o[i].d_valid;
    end
    chk(v.name,
        {51'd0, bus.tl_d_o.a_valid, got_ar, got_dv, bus.tl_d_o.d_ready, bus.busy_o, bus.err_o},
        {51'd0, v.e_av, v.e_ar, v.e_dv, v.e_dr, v.e_busy, v.e_err});
    if (v.e_av) begin
      chk({v.name, "_req"}, {bus.tl_d_o.a_source, 24'd0, bus.tl_d_o.a_data},
          {v.e_src, 24'd0, 32'hA000 | {24'd0, v.e_src}});
    end
    for (int i = 0; i < 4; i++) begin
      if (v.e_dv[i]) chk({v.name, "_ddata"}, {32'd0, bus.tl_h_o[i].d_data}, {32'd0, v.dd});
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      bus.tl_h_i[i]          = '0;
      bus.tl_h_i[i].a_source = 8'h10 + 8'(i);
      bus.tl_h_i[i].a_data   = 32'hA010 + 32'(i);
      bus.tl_h_i[i].a_opcode = 3'd4;
      bus.tl_h_i[i].a_mask   = 4'hF;
    end
    bus.tl_d_i = '0;

    // reset / idle
    add("idle",   4'b0000, 0, 0, 4'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 0);
    // round robin among hosts 0..2 with wrap
    add("rr0",    4'b0111, 1, 0, 4'h0, 0, 1, 8'h10, 4'b0001, 4'b0000, 0, 0, 0);
    add("rr1",    4'b0111, 1, 0, 4'h0, 0, 1, 8'h11, 4'b0010, 4'b0000, 0, 1, 0);
    add("rr2",    4'b0111, 1, 0, 4'h0, 0, 1, 8'h12, 4'b0100, 4'b0000, 0, 1, 0);
    add("rr0w",   4'b0111, 1, 0, 4'h0, 0, 1, 8'h10, 4'b0001, 4'b0000, 0, 1, 0);
    add("rr1b",   4'b0111, 1, 0, 4'h0, 0, 1, 8'h11, 4'b0010, 4'b0000, 0, 1, 0);
    add("rr2b",   4'b0111, 1, 0, 4'h0, 0, 1, 8'h12, 4'b0100, 4'b0000, 0, 1, 0);
    perf_at = vq.size();
    for (int k = 0; k < 6; k++)
      add("rsp_order", 4'b0000, 0, 1, 4'hF, 32'hD000 + 32'(k), 0, 8'h00, 4'b0000,
          4'(1 << (k % 3)), 1, 1, 0);
    add("idle2",  4'b0000, 0, 0, 4'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 0);
    // grant lock: host 1 stalled, host 2 then host 0 arrive meanwhile
    add("hold1",  4'b0010, 0, 0, 4'h0, 0, 1, 8'h11, 4'b0000, 4'b0000, 0, 0, 0);
    add("hold2",  4'b0110, 0, 0, 4'h0, 0, 1, 8'h11, 4'b0000, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add("hold3",4'b0111, 0, 0, 4'h0, 0, 1, 8'h11, 4'b0000, 4'b0000, 0, 0, 0);
    add("hold_acc", 4'b0111, 1, 0, 4'h0, 0, 1, 8'h11, 4'b0010, 4'b0000, 0, 0, 0);
    add("after_h2", 4'b0101, 1, 0, 4'h0, 0, 1, 8'h12, 4'b0100, 4'b0000, 0, 1, 0);
    add("after_h0", 4'b0001, 1, 0, 4'h0, 0, 1, 8'h10, 4'b0001, 4'b0000, 0, 1, 0);
    // push+pop at occupancy 3, then head host 2 stalls d_ready
    add("pushpop",  4'b1000, 1, 1, 4'hF, 32'hE1, 1, 8'h13, 4'b1000, 4'b0010, 1, 1, 0);
    add("h2_stall", 4'b0000, 0, 1, 4'b1011, 32'hE2, 0, 8'h00, 4'b0000, 4'b0100, 0, 1, 0);
    add("h2_go",    4'b0000, 0, 1, 4'b0100, 32'hE2, 0, 8'h00, 4'b0000, 4'b0100, 1, 1, 0);
    add("pop_h0",   4'b0000, 0, 1, 4'hF, 32'hE3, 0, 8'h00, 4'b0000, 4'b0001, 1, 1, 0);
    add("pop_h3",   4'b0000, 0, 1, 4'hF, 32'hE4, 0, 8'h00, 4'b0000, 4'b1000, 1, 1, 0);
    add("idle3",    4'b0000, 0, 0, 4'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 0);
    // fill to 8 outstanding, 9th stalls until a pop has been registered
    for (int k = 0; k < 8; k++)
      add("fill",   4'b0001, 1, 0, 4'h0, 0, 1, 8'h10, 4'b0001, 4'b0000, 0, k > 0, 0);
    add("full9",    4'b0001, 1, 0, 4'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 1, 0);
    add("full_pop", 4'b0001, 1, 1, 4'hF, 32'hF0, 0, 8'h00, 4'b0000, 4'b0001, 1, 1, 0);
    add("acc9",     4'b0001, 1, 0, 4'h0, 0, 1, 8'h10, 4'b0001, 4'b0000, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      add("drain",  4'b0000, 0, 1, 4'hF, 32'hF1 + 32'(k), 0, 8'h00, 4'b0000, 4'b0001, 1, 1, 0);
    add("idle4",    4'b0000, 0, 0, 4'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 0);
    // spurious response: sunk, then sticky error
    add("spur",     4'b0000, 0, 1, 4'h0, 32'hBAD, 0, 8'h00, 4'b0000, 4'b0000, 1, 0, 0);
    add("sticky1",  4'b0000, 0, 0, 4'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 1);
    add("sticky2",  4'b0010, 1, 0, 4'h0, 0, 1, 8'h11, 4'b0010, 4'b0000, 0, 0, 1);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
`ifdef MEM_ARB_PERF_CNT_EN
      if (k == perf_at) begin
        @(negedge clk_i);
        chk("perf_grant", {perf_grant[3], perf_grant[2]}, {32'd0, 32'd2});
        chk("perf_grant01", {perf_grant[1], perf_grant[0]}, {32'd2, 32'd2});
      end
`endif
      apply(vq[k]);
    end

    // Reset with one request in flight (host 1 accepted above, rr_ptr=2).
    @(negedge clk_i);
    drive(mk("rst", 4'b0000, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_clear", {61'd0, bus.busy_o, bus.err_o, bus.tl_d_o.a_valid}, 64'd0);
    // rr_ptr cleared: host 1 wins over host 2.
    apply(mk("rst_rr", 4'b0110, 1, 0, 4'h0, 0, 1, 8'h11, 4'b0010, 4'b0000, 0, 0, 0));
    apply(mk("rst_busy", 4'b0000, 0, 0, 4'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlul_mem_arbiter.md
Name: tlul_mem_arbiter

Overview:
Shares the single main-memory TL-UL device port (the DDR4 TL-UL bridge) between NumHosts TL-UL hosts, e.g. the management-core DMA and the vector-core DMAs.
- Request side uses round-robin arbitration with grant lock while a beat is stalled.
- Response side uses an in-order routing FIFO of granted host indices; the memory returns responses in request order.
- Sits between the multicore system and the DDR4 bridge, in the clk_sys domain.

Parameters:
NumHosts, 4, number of requesting TL-UL hosts (2..8).
MaxOutstanding, 8, routing FIFO depth (power of 2, ≥2); maximum in-flight requests across all hosts.
HostIdxW, $clog2(NumHosts), localparam, width of a host index.

Ports:
clk_i  in  1  system clock (clk_sys)
rst_i  in  1  synchronous active-high reset
tl_h_i  in  NumHosts x tl_h2d_t  host requests
tl_h_o  out  NumHosts x tl_d2h_t  host responses
tl_d_o  out  tl_h2d_t  to main-memory device
tl_d_i  in  tl_d2h_t  from main-memory device
busy_o  out  1  routing FIFO non-empty
err_o  out  1  sticky: device response received with routing FIFO empty

Behaviour:
- Interfaces:
  - Only clock is clk_i. Reset is rst_i: synchronous, active-high.
  - All A-channel fields except valid/ready pass through unmodified, including a_source. d_* fields are broadcast to all hosts; only d_valid is qualified.
- Reset values:
  - FSM=ARB, rr_ptr=0, FIFO empty, err_o=0, busy_o=0.
  - tl_d_o.a_valid=0 and tl_d_o.d_ready=0 while the FIFO is empty.
  - All tl_h_o a_ready=0 and d_valid=0.
- FSM ARB:
  - If the FIFO is not full, winner = first host with a_valid, searching from rr_ptr upward with wrap-around.
  - The winner's request drives tl_d_o combinationally. tl_h_o[winner].a_ready = tl_d_i.a_ready.
  - On acceptance (a_valid & a_ready): push winner into the FIFO and set rr_ptr = winner+1, wrapping at NumHosts-1 → 0. Stay in ARB.
  - If a winner is presented and a_ready=0: latch winner into lock_idx and go to HOLD.
- FSM HOLD:
  - tl_d_o carries tl_h_i[lock_idx] only; other hosts see a_ready=0.
  - On acceptance: push lock_idx, set rr_ptr = lock_idx+1, go to ARB.
  - A host withdrawing a_valid in HOLD is a TL protocol violation. The arbiter simply stays in HOLD until valid & ready.
- Zero-bubble: back-to-back acceptances on consecutive cycles are supported in ARB; latency A→device is 0 cycles (combinational).
- FIFO full: no new grant. In ARB, tl_d_o.a_valid=0 and all a_ready=0, even if a pop occurs in the same cycle. HOLD cannot be entered while full.
- Response routing:
  - If FIFO non-empty: head = FIFO head. tl_h_o[head].d_valid = tl_d_i.d_valid. tl_d_o.d_ready = tl_h_i[head].d_ready.
  - Pop on d_valid & d_ready. Response latency is 0 cycles (combinational).
- Simultaneous push and pop in one cycle: both occur; occupancy unchanged.
- Spurious response (d_valid while FIFO empty): tl_d_o.d_ready=1 for that cycle, beat dropped, err_o set until reset.
- Reset mid-operation: FIFO, lock and pointer are cleared and in-flight responses are lost. The DDR4 bridge shares the reset and is reset simultaneously.

Optional Feature:
Macro MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_grant_o (NumHosts x 32): per-host accepted-request counters.
  - Adds output perf_stall_o (32): cycles where any host has a_valid but no acceptance occurs.
  - Counters saturate at 32'hFFFF_FFFF and clear on rst_i.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- tlul_mem_arb_pkg: arb_state_e {ARB, HOLD}, a default MaxOutstanding constant, and a host_idx_t helper sized by the parameter.
- One sub-module, tlul_mem_arb_fifo: synchronous FIFO of HostIdxW entries with push/pop/full/empty, same clock and reset. The top keeps arbitration, the FSM and counters.

Test Plan:
1. Reset, then idle: all a_ready=0, tl_d_o.a_valid=0, busy_o=0, err_o=0.
2. Hosts 0,1,2 hold a_valid with device a_ready=1 → accept order 0,1,2,0,1,2; rr_ptr wraps; device responses are routed in the same order with matching d_data.
3. Host 1 requests with device a_ready=0 for 5 cycles, and host 2 raises a_valid at cycle 2 → tl_d_o carries host 1 throughout. Host 1 is accepted on cycle 6 and host 2 is granted next.
4. MaxOutstanding=8: with no responses, 8 requests are accepted and the 9th stalls (a_ready=0). One response pop lets the 9th be accepted on the following cycle, not the same cycle.
5. Push and pop in the same cycle at occupancy 3 → occupancy stays 3; head host 2's response is seen only on tl_h_o[2].d_valid while host 2 d_ready=0 stalls tl_d_o.d_ready.
6. d_valid injected with FIFO empty → d_ready=1 and err_o=1 sticky until rst_i. With MEM_ARB_PERF_CNT_EN defined, perf_grant_o matches the counts from scenario 2 (2 each for hosts 0–2).
